// File: rtl/clk_div_prog.sv
`timescale 1ns/1ps
// Programmable clock divider: clk_out = clk/N at 50% duty for even and odd N, with glitch-free divisor changes and stops.
// Latency: a new divisor applies at the next period wrap (or on IDLE->RUN); loads never stall, a later load overwrites the pending one.
module clk_div_prog #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_active,
    output logic             load_err
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOPPING} state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_div_active, w_div_nxt;
    logic [WIDTH-1:0] r_pend_val, w_pend_val_nxt;
    logic             r_pend_vld, w_pend_vld_nxt;
    logic             r_pos_q, w_pos_nxt;
    logic             r_neg_q;
    logic             r_tick, w_tick_nxt;
    logic             r_load_err;
    logic             w_load_ok, w_running, w_wrap, w_apply, w_run_nxt;
    logic [WIDTH:0]   w_half_nxt;

    assign w_load_ok = div_load && (div > ONE);
    assign w_running = (r_state != ST_IDLE);
    assign w_wrap    = w_running && (r_cnt == r_div_active - ONE);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_div_nxt      = r_div_active;
        w_pend_val_nxt = r_pend_val;
        w_pend_vld_nxt = r_pend_vld;
        w_apply        = 1'b0;

        if (w_load_ok) begin
            w_pend_val_nxt = div;
            w_pend_vld_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    w_apply     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_wrap) begin
                    w_cnt_nxt = '0;
                    w_apply   = 1'b1;
                    if (!en) w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                    if (!en) w_state_nxt = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (w_wrap) begin
                    w_cnt_nxt   = '0;
                    w_apply     = 1'b1;
                    w_state_nxt = en ? ST_RUN : ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                    if (en) w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A load arriving in the wrap cycle is already folded into the pending value here.
        if (w_apply && w_pend_vld_nxt) begin
            w_div_nxt      = w_pend_val_nxt;
            w_pend_vld_nxt = 1'b0;
        end

        w_run_nxt  = (w_state_nxt != ST_IDLE);
        w_half_nxt = ({1'b0, w_div_nxt} + ONE_X) >> 1;
        w_pos_nxt  = w_run_nxt && ({1'b0, w_cnt_nxt} < w_half_nxt);
        w_tick_nxt = w_run_nxt && (w_cnt_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_div_active <= DEF_DIV;
            r_pend_val   <= DEF_DIV;
            r_pend_vld   <= 1'b0;
            r_pos_q      <= 1'b0;
            r_tick       <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_div_active <= w_div_nxt;
            r_pend_val   <= w_pend_val_nxt;
            r_pend_vld   <= w_pend_vld_nxt;
            r_pos_q      <= w_pos_nxt;
            r_tick       <= w_tick_nxt;
            r_load_err   <= div_load && (div <= ONE);
        end
    end

    // Half-cycle stage: follows pos_q for odd N and holds 1 for even N. Parity is taken from the
    // divisor of the upcoming edge, so a parity switch lands while pos_q is low and the AND stays glitch-free.
    always_ff @(negedge clk) begin
        if (rst) r_neg_q <= 1'b0;
        else     r_neg_q <= r_pos_q | ~w_div_nxt[0];
    end

    assign clk_out    = r_pos_q & r_neg_q;
    assign tick       = r_tick;
    assign div_active = r_div_active;
    assign load_err   = r_load_err;
endmodule

// File: tb/tb_clk_div_prog.sv
`timescale 1ns/1ps
// Directed bench for clk_div_prog: reset state, odd/even periods, divisor changes, stop/restart, load errors, reset mid-period.
module tb_clk_div_prog;
    logic       clk = 1'b0;
    logic       rst, en, div_load;
    logic [7:0] div;
    logic       clk_out, tick, load_err;
    logic [7:0] div_active;
    int n_cmp = 0;
    int n_err = 0;

    clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
        .clk(clk), .rst(rst), .en(en), .div(div), .div_load(div_load),
        .clk_out(clk_out), .tick(tick), .div_active(div_active), .load_err(load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_div(input logic [7:0] n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (tick === 1'b1 && div_active === n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Counts high and low half-cycles of one full clk_out period after the next rising edge.
    task automatic measure(output int hi, output int lo, output bit ok);
        int guard = 0;
        hi = 0;
        lo = 0;
        while (clk_out !== 1'b0 && guard < 4000) begin half(); guard++; end
        while (clk_out !== 1'b1 && guard < 4000) begin half(); guard++; end
        while (clk_out === 1'b1 && guard < 4000) begin hi++; half(); guard++; end
        while (clk_out === 1'b0 && guard < 4000) begin lo++; half(); guard++; end
        ok = (guard < 4000);
    endtask

    initial begin
        logic [11:0] v12;
        logic [7:0]  v8;
        logic [5:0]  v6;
        int          hi, lo;
        bit          ok;
        int          sweep [4] = '{2, 5, 8, 255};

        rst = 1'b1; en = 1'b0; div = 8'd0; div_load = 1'b0;
        cyc();
        cyc();
        check("rst_tick",     32'(tick),       32'd0);
        check("rst_load_err", 32'(load_err),   32'd0);
        check("rst_div",      32'(div_active), 32'd3);
        check("rst_clk_out",  32'(clk_out),    32'd0);

        // Default N=3 after enable
        rst = 1'b0; en = 1'b1;
        v6 = '0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            v6 = {v6[4:0], tick};
        end
        check("n3_ticks", 32'(v6), 32'(6'b100100));
        measure(hi, lo, ok);
        check("n3_ok", 32'(ok), 32'd1);
        check("n3_hi", 32'(hi), 32'd3);
        check("n3_lo", 32'(lo), 32'd3);

        // Load 4 mid-period: current 3-cycle period completes first
        wait_div(8'd3, ok);
        check("ld4_sync", 32'(ok), 32'd1);
        div_load = 1'b1; div = 8'd4;
        cyc();
        div_load = 1'b0;
        check("ld4_cnt1_div", 32'(div_active), 32'd3);
        cyc();
        check("ld4_cnt2_div", 32'(div_active), 32'd3);
        cyc();
        check("ld4_wrap_div", 32'(div_active), 32'd4);
        v8 = '0;
        for (int i = 0; i < 8; i++) begin
            v8 = {v8[6:0], tick};
            if (i < 7) cyc();
        end
        check("n4_ticks", 32'(v8), 32'(8'b10001000));
        measure(hi, lo, ok);
        check("n4_ok", 32'(ok), 32'd1);
        check("n4_hi", 32'(hi), 32'd4);
        check("n4_lo", 32'(lo), 32'd4);

        // Load presented in the wrap cycle takes effect at that wrap
        wait_div(8'd4, ok);
        check("ld6_sync", 32'(ok), 32'd1);
        cyc(); cyc(); cyc();
        div_load = 1'b1; div = 8'd6;
        cyc();
        div_load = 1'b0;
        check("ld6_wrap_div",  32'(div_active), 32'd6);
        check("ld6_wrap_tick", 32'(tick),       32'd1);

        // Stop requested at cnt=1 with N=6
        cyc();
        en = 1'b0;
        cyc();
        v12 = '0; v6 = '0;
        for (int i = 0; i < 12; i++) begin
            v12 = {v12[10:0], clk_out};
            if (i % 2 == 0) v6 = {v6[4:0], tick};
            half();
        end
        check("stop_wave",  32'(v12), 32'(12'b110000000000));
        check("stop_ticks", 32'(v6),  32'(6'b000000));

        // Restart: full 3-cycle high phase first
        en = 1'b1;
        cyc();
        v12 = '0; v6 = '0;
        for (int i = 0; i < 12; i++) begin
            v12 = {v12[10:0], clk_out};
            if (i % 2 == 0) v6 = {v6[4:0], tick};
            half();
        end
        check("restart_wave",  32'(v12), 32'(12'b111111000000));
        check("restart_ticks", 32'(v6),  32'(6'b100000));

        // Illegal divisors 1 and 0
        cyc();
        div_load = 1'b1; div = 8'd1;
        cyc();
        div_load = 1'b0;
        check("lerr1_pulse", 32'(load_err),   32'd1);
        check("lerr1_div",   32'(div_active), 32'd6);
        cyc();
        check("lerr1_clear", 32'(load_err),   32'd0);
        div_load = 1'b1; div = 8'd0;
        cyc();
        div_load = 1'b0;
        check("lerr0_pulse", 32'(load_err),   32'd1);
        cyc();
        check("lerr0_clear", 32'(load_err),   32'd0);
        wait_div(8'd6, ok);
        wait_div(8'd6, ok);
        check("lerr_div_kept", 32'(ok), 32'd1);

        // Divisor sweep
        for (int k = 0; k < 4; k++) begin
            cyc();
            div_load = 1'b1; div = 8'(sweep[k]);
            cyc();
            div_load = 1'b0;
            wait_div(8'(sweep[k]), ok);
            check($sformatf("sweep_sync_n%0d", sweep[k]), 32'(ok), 32'd1);
            measure(hi, lo, ok);
            check($sformatf("sweep_ok_n%0d", sweep[k]), 32'(ok), 32'd1);
            check($sformatf("sweep_hi_n%0d", sweep[k]), 32'(hi), 32'(sweep[k]));
            check($sformatf("sweep_lo_n%0d", sweep[k]), 32'(lo), 32'(sweep[k]));
        end

        // Reset while clk_out is high with N=7 and a divisor pending
        cyc();
        div_load = 1'b1; div = 8'd7;
        cyc();
        div_load = 1'b0;
        wait_div(8'd7, ok);
        check("n7_sync", 32'(ok), 32'd1);
        div_load = 1'b1; div = 8'd9;
        cyc();
        div_load = 1'b0;
        check("n7_high_before_rst", 32'(clk_out), 32'd1);
        rst = 1'b1;
        cyc();
        check("rst_mid_clk_out", 32'(clk_out),    32'd0);
        check("rst_mid_tick",    32'(tick),       32'd0);
        check("rst_mid_div",     32'(div_active), 32'd3);
        half();
        check("rst_mid_clk_out_neg", 32'(clk_out), 32'd0);
        rst = 1'b0;
        cyc();
        check("rst_resume_tick", 32'(tick),       32'd1);
        check("rst_resume_div",  32'(div_active), 32'd3);
        measure(hi, lo, ok);
        check("rst_resume_ok", 32'(ok), 32'd1);
        check("rst_resume_hi", 32'(hi), 32'd3);
        check("rst_resume_lo", 32'(lo), 32'd3);
        for (int i = 0; i < 7; i++) cyc();
        check("rst_pend_cleared", 32'(div_active), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, 8, width of divisor ports and internal counter.
REQ-002 Parameter DEFAULT_DIV, 3, divisor loaded at reset; SHALL be in range 2..2^WIDTH-1.
REQ-003 clk  input  1  clock; counter logic on rising edge, half-cycle stage on falling edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  run enable; low requests a glitch-free stop at the end of the current period.
REQ-006 div  input  WIDTH  requested divisor N; sampled only when div_load=1.
REQ-007 div_load  input  1  one-cycle request to latch div into the pending register.
REQ-008 clk_out  output  1  divided clock, frequency clk/N, 50% duty for both even and odd N.
REQ-009 tick  output  1  one-clk pulse in the first cycle of each output period; posedge domain.
REQ-010 div_active  output  WIDTH  divisor currently in effect.
REQ-011 load_err  output  1  one-cycle pulse when div_load is presented with div<2.

Function
REQ-012 cnt SHALL count 0..N-1 on each rising clk edge while running, then wrap to 0; N=div_active.
REQ-013 H SHALL equal ceil(N/2); pos_q SHALL be registered on the rising edge and high exactly while cnt is in 0..H-1.
REQ-014 neg_q SHALL capture pos_q on each falling clk edge.
REQ-015 Even N: clk_out SHALL equal pos_q, giving N/2 cycles high and N/2 cycles low.
REQ-016 Odd N: clk_out SHALL equal pos_q AND neg_q, giving N/2 cycles high (half-cycle resolution) and N/2 cycles low.
REQ-017 clk_out SHALL be glitch-free. Its only combinational source is a 2-input AND of flop outputs. The even/odd select SHALL change only at a period boundary while pos_q=0.
REQ-018 div_load=1 with div>=2 SHALL latch div into the pending register and set the pending flag; a later load SHALL overwrite the pending value.
REQ-019 div_load=1 with div<2 SHALL be ignored, with load_err=1 on the following cycle.
REQ-020 The pending value SHALL become div_active at the rising edge where cnt wraps from N-1 to 0, and that new period SHALL use the new N. The pending flag SHALL clear at the same edge.
REQ-021 If div_load and the wrap occur in the same cycle, the newly loaded value SHALL take effect at that wrap.
REQ-022 tick SHALL be 1 for exactly one cycle whenever cnt=0 while running, and 0 otherwise.
REQ-023 States are IDLE, RUN and STOPPING.
 - IDLE->RUN on en=1; the first period starts with cnt=0 on the next edge.
 - RUN->STOPPING on en=0.
 - STOPPING->IDLE at the wrap.
 - STOPPING->RUN if en returns to 1 before the wrap, with no gap.
REQ-024 In IDLE, cnt=0, pos_q=0, clk_out=0 and tick=0; a pending divisor SHALL apply at the IDLE->RUN transition.

Reset
REQ-025 rst=1 at a rising edge SHALL set: state=IDLE, cnt=0, pos_q=0, tick=0, load_err=0, div_active=DEFAULT_DIV, pending cleared.
REQ-026 neg_q SHALL clear at the first falling edge with rst=1, so clk_out=0 within half a cycle of the reset edge.
REQ-027 rst asserted mid-period SHALL drop clk_out to 0 without a runt-high pulse; operation resumes from IDLE.

Verification
REQ-028 DEFAULT_DIV=3, en=1 after reset -> clk_out period 3 clk, high 1.5 clk; tick every 3rd cycle.
REQ-029 div_load with div=4 mid-period -> the current 3-cycle period completes, then periods of 4 cycles with 2 high and 2 low; div_active=4 from the wrap edge.
REQ-030 Sweep N=2,5,8,255 -> measured period N clk, duty 50% ±0 half-cycles; no glitch on any N switch.
REQ-031 en=0 at cnt=1 with N=6 -> the period finishes, then clk_out=0 held. en=1 again -> a full high phase of 3 cycles first.
REQ-032 div_load with div=1 -> load_err pulse, div_active unchanged. div_load with div=0 -> same.
REQ-033 rst pulsed while clk_out=1 with N=7 -> clk_out=0 by the next falling edge, div_active=3, tick=0.
